imem_loader: RTL

- Writer side of the instruction memory that InstructionFetch reads by pc.
- Accepts a byte stream with a valid/ready handshake and assembles 32-bit instruction words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses.
- Holds the CPU core stalled while a program load is in progress.

---
 rtl/kgp_risc_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_word_assembler.sv | 38 +++
 rtl/imem_loader.sv | 139 +++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the instruction-side datapath: the loader state
// encoding plus the instruction width and instruction-memory address width
// that InstructionFetch and the pc logic also use.
package kgp_risc_pkg;

  localparam int INSTR_W     = 32;
  localparam int IMEM_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle for the instruction-memory loader.
// Groups the load control (start/base_addr/word_count/abort), the byte stream
// (in_data/in_valid/in_ready), the memory write port (wr_en/wr_addr/wr_data)
// and the status outputs (busy/cpu_hold/done/err).
// slave  : the loader side
// master : the controller / stream source / memory side
interface imem_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [10:0]       word_count;
  logic              abort;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport slave (
    input  start, base_addr, word_count, abort, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err
  );

  modport master (
    output start, base_addr, word_count, abort, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_word_assembler.sv
// Collects a big-endian byte stream into 32-bit instruction words.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   clr         : drop any partial word and restart at byte 0
//   shift_en    : accept in_data this cycle
//   in_data     : stream byte
//   word        : assembled word (first byte ends up in [31:24])
//   word_full   : this cycle's byte completes the word
module imem_word_assembler
  import kgp_risc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic [7:0]         in_data,
  output logic [INSTR_W-1:0] word,
  output logic               word_full
);

  logic [1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      idx  <= 2'd0;
    end else if (clr) begin
      word <= '0;
      idx  <= 2'd0;
    end else if (shift_en) begin
      word <= {word[INSTR_W-9:0], in_data};
      idx  <= idx + 2'd1;
    end
  end

  assign word_full = shift_en && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a byte stream into words and writes
// them to consecutive word addresses, holding the core stalled meanwhile.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   bus      : imem_loader_if slave (load control, byte stream,
//              memory write port, busy/cpu_hold/done/err status)
//
// state | meaning
// IDLE  | waiting for start; range check done on the start cycle
// RECV  | accepting stream bytes into the assembler
// WRITE | one-cycle memory write of the assembled word
// DONE  | one-cycle completion pulse, err reports range error or abort
module imem_loader
  import kgp_risc_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DATA_W    = INSTR_W,
  parameter int MEM_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  // Wide enough for (max word index + max word_count) without overflow.
  localparam int SUM_W = ADDR_W + 2;

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [10:0]       remaining;
  logic              err_q, err_nxt;
  logic              load, step, clr, shift_en;
  logic              word_full;
  logic [DATA_W-1:0] word;
  logic [SUM_W-1:0]  end_word;
  logic              range_err;

  imem_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .in_data  (bus.in_data),
    .word     (word),
    .word_full(word_full)
  );

  // Shifting the full address drops the byte offset bits.
  assign end_word  = (SUM_W'(bus.base_addr) >> 2) + SUM_W'(bus.word_count);
  assign range_err = end_word > SUM_W'(MEM_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (load) begin
        addr      <= bus.base_addr & ~ADDR_W'(3);
        remaining <= bus.word_count;
      end else if (step) begin
        addr      <= addr + ADDR_W'(4);
        remaining <= remaining - 11'd1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    err_nxt      = err_q;
    load         = 1'b0;
    step         = 1'b0;
    clr          = 1'b0;
    shift_en     = 1'b0;
    bus.in_ready = 1'b0;
    bus.wr_en    = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load = 1'b1;
          clr  = 1'b1;
          if (range_err) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else if (bus.word_count == 11'd0) begin
            state_nxt = DONE;
            err_nxt   = 1'b0;
          end else begin
            state_nxt = RECV;
            err_nxt   = 1'b0;
          end
        end
      end
      RECV: begin
        bus.in_ready = 1'b1;
        if (bus.abort) begin
          clr       = 1'b1;
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else begin
          shift_en = bus.in_valid;
          if (word_full) state_nxt = WRITE;
        end
      end
      WRITE: begin
        bus.wr_en = 1'b1;
        step      = 1'b1;
        if (bus.abort) begin
          clr       = 1'b1;
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (remaining == 11'd1) begin
          state_nxt = DONE;
          err_nxt   = 1'b0;
        end else begin
          state_nxt = RECV;
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        bus.err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data are only meaningful with the strobe; hold them at 0 otherwise.
  assign bus.wr_addr  = bus.wr_en ? addr : '0;
  assign bus.wr_data  = bus.wr_en ? word : '0;
  assign bus.busy     = (state != IDLE);
  assign bus.cpu_hold = bus.busy;

endmodule
